// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to voice slots (retrigger, free voice, else steal/drop).
// Define VOICE_ALLOC_STEAL_EN to steal the oldest voice when all are busy; default build drops the note.
//
// state  | meaning
// IDLE   | ready for an event; all_off_in honoured here
// SCAN   | examine one voice per cycle, index 0..NUM_VOICES-1
// COMMIT | apply the chosen update, pulse steal/drop, return to IDLE
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_WIDTH = 7,
    parameter int AGE_WIDTH  = 16
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             note_valid_in,
    output logic                             note_ready_out,
    input  logic                             note_on_in,
    input  logic [NOTE_WIDTH-1:0]            note_in,
    input  logic [6:0]                       velocity_in,
    input  logic                             all_off_in,
    output logic [NUM_VOICES-1:0]            gate_out,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note_out,
    output logic [NUM_VOICES*7-1:0]          voice_vel_out,
    output logic [$clog2(NUM_VOICES+1)-1:0]  active_count_out,
    output logic                             steal_out,
    output logic                             drop_out
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;
    state_t state_q, state_d;

    logic [NUM_VOICES-1:0] gate_q;
    logic [NOTE_WIDTH-1:0] note_q [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];

    logic                  ev_on_q;
    logic [NOTE_WIDTH-1:0] ev_note_q;
    logic [6:0]            ev_vel_q;

    logic [IDX_W-1:0]      scan_idx_q;
    logic                  match_found_q, free_found_q;
    logic [IDX_W-1:0]      match_idx_q, free_idx_q;
    logic [NUM_VOICES-1:0] off_mask_q;
    logic                  steal_q, drop_q;

    logic                  accept, panic, scan_hit;
    logic                  steal_en;
    logic [IDX_W-1:0]      victim_idx;
    logic                  do_assign, do_steal, do_drop;
    logic [IDX_W-1:0]      tgt_idx;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        note_ready_out = 1'b0;
        accept         = 1'b0;
        panic          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                note_ready_out = 1'b1;
                panic          = all_off_in;
                accept         = note_valid_in && !all_off_in;
                if (accept) state_d = ST_SCAN;
            end
            ST_SCAN:   if (scan_idx_q == LAST_IDX) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign scan_hit = gate_q[scan_idx_q] && (note_q[scan_idx_q] == ev_note_q);

`ifdef VOICE_ALLOC_STEAL_EN
    // Ages only influence which voice gets stolen, so they exist only in this build.
    logic [AGE_WIDTH-1:0] age_q [NUM_VOICES];
    logic                 old_found_q;
    logic [IDX_W-1:0]     old_idx_q;
    logic [AGE_WIDTH-1:0] old_age_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
            old_found_q <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (panic) begin
                        for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
                    end else if (accept) begin
                        old_found_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps the lowest index on equal ages.
                    if (gate_q[scan_idx_q] &&
                        (!old_found_q || age_q[scan_idx_q] > old_age_q)) begin
                        old_found_q <= 1'b1;
                        old_idx_q   <= scan_idx_q;
                        old_age_q   <= age_q[scan_idx_q];
                    end
                end
                ST_COMMIT: begin
                    if (do_assign) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == tgt_idx)
                                age_q[i] <= '0;
                            else if (gate_q[i] && age_q[i] != '1)
                                age_q[i] <= age_q[i] + AGE_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign steal_en   = 1'b1;
    assign victim_idx = old_idx_q;
`else
    assign steal_en   = 1'b0;
    assign victim_idx = '0;
`endif

    always_comb begin
        do_assign = 1'b0;
        do_steal  = 1'b0;
        do_drop   = 1'b0;
        tgt_idx   = match_idx_q;
        if (ev_on_q) begin
            if (match_found_q) begin
                do_assign = 1'b1;
            end else if (free_found_q) begin
                do_assign = 1'b1;
                tgt_idx   = free_idx_q;
            end else if (steal_en) begin
                do_assign = 1'b1;
                do_steal  = 1'b1;
                tgt_idx   = victim_idx;
            end else begin
                do_drop   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gate_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
            end
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            off_mask_q    <= '0;
            steal_q       <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            steal_q <= 1'b0;
            drop_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (panic) begin
                        gate_q <= '0;
                    end else if (accept) begin
                        // A zero-velocity note-on is a note-off by MIDI convention.
                        ev_on_q       <= note_on_in && (velocity_in != 7'd0);
                        ev_note_q     <= note_in;
                        ev_vel_q      <= velocity_in;
                        scan_idx_q    <= '0;
                        match_found_q <= 1'b0;
                        free_found_q  <= 1'b0;
                        off_mask_q    <= '0;
                    end
                end
                ST_SCAN: begin
                    scan_idx_q <= scan_idx_q + IDX_W'(1);
                    if (scan_hit && !match_found_q) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= scan_idx_q;
                    end
                    if (!gate_q[scan_idx_q] && !free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= scan_idx_q;
                    end
                    if (scan_hit) off_mask_q[scan_idx_q] <= 1'b1;
                end
                ST_COMMIT: begin
                    if (!ev_on_q) begin
                        gate_q <= gate_q & ~off_mask_q;
                    end else if (do_assign) begin
                        gate_q[tgt_idx] <= 1'b1;
                        note_q[tgt_idx] <= ev_note_q;
                        vel_q[tgt_idx]  <= ev_vel_q;
                    end
                    steal_q <= do_steal;
                    drop_q  <= do_drop;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        voice_note_out   = '0;
        voice_vel_out    = '0;
        active_count_out = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note_out[i*NOTE_WIDTH +: NOTE_WIDTH] = note_q[i];
            voice_vel_out[i*7 +: 7]                    = vel_q[i];
            active_count_out = active_count_out + CNT_W'(gate_q[i]);
        end
    end

    assign gate_out  = gate_q;
    assign steal_out = steal_q;
    assign drop_out  = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed table, corner sequences, random events vs. an event-level model.
module tb_voice_allocator;
    localparam int NV      = 8;
    localparam int AGE_MAX = 7;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        note_valid_in = 1'b0;
    logic        note_ready_out;
    logic        note_on_in = 1'b0;
    logic [6:0]  note_in = '0;
    logic [6:0]  velocity_in = '0;
    logic        all_off_in = 1'b0;
    logic [7:0]  gate_out;
    logic [55:0] voice_note_out;
    logic [55:0] voice_vel_out;
    logic [3:0]  active_count_out;
    logic        steal_out;
    logic        drop_out;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(7), .AGE_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .note_valid_in(note_valid_in), .note_ready_out(note_ready_out),
        .note_on_in(note_on_in), .note_in(note_in), .velocity_in(velocity_in),
        .all_off_in(all_off_in), .gate_out(gate_out),
        .voice_note_out(voice_note_out), .voice_vel_out(voice_vel_out),
        .active_count_out(active_count_out),
        .steal_out(steal_out), .drop_out(drop_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    bit         m_gate [NV];
    logic [6:0] m_note [NV];
    logic [6:0] m_vel  [NV];
    int         m_age  [NV];

    typedef struct {
        bit         on;
        logic [6:0] note;
        logic [6:0] vel;
        logic [7:0] gate;
        int         cnt;
        int         vi;
        logic [6:0] vnote;
        logic [6:0] vvel;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = '0; m_vel[i] = '0; m_age[i] = 0;
        end
    endtask

    // Event-level reference: priority rules applied directly to the voice table.
    task automatic model_event(input bit on, input logic [6:0] n, input logic [6:0] v,
                               output bit st, output bit dr);
        int tgt;
        st = 0; dr = 0; tgt = -1;
        if (!(on && v != 0)) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == n) m_gate[i] = 0;
            return;
        end
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && !m_gate[i]) tgt = i;
        if (tgt < 0) begin
`ifdef VOICE_ALLOC_STEAL_EN
            tgt = 0;
            for (int i = 1; i < NV; i++)
                if (m_age[i] > m_age[tgt]) tgt = i;
            st = 1;
`else
            dr = 1;
            return;
`endif
        end
        for (int i = 0; i < NV; i++)
            if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
        m_gate[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v; m_age[tgt] = 0;
    endtask

    task automatic model_check(input string tag);
        logic [7:0]  eg;
        logic [55:0] en, ev;
        int c;
        eg = '0; en = '0; ev = '0; c = 0;
        for (int i = 0; i < NV; i++) begin
            eg[i] = m_gate[i];
            en[i*7 +: 7] = m_note[i];
            ev[i*7 +: 7] = m_vel[i];
            c += int'(m_gate[i]);
        end
        chk({tag, "_gate"}, gate_out, eg);
        chk({tag, "_notes"}, voice_note_out, en);
        chk({tag, "_vels"}, voice_vel_out, ev);
        chk({tag, "_count"}, active_count_out, c);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 0; note_valid_in = 0; all_off_in = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_ready", note_ready_out, 1);
        chk("rst_gate", gate_out, 0);
        chk("rst_notes", voice_note_out, 0);
        chk("rst_vels", voice_vel_out, 0);
        chk("rst_count", active_count_out, 0);
        chk("rst_steal", steal_out, 0);
        chk("rst_drop", drop_out, 0);
        rst_n_in = 1;
        model_clear();
    endtask

    // One full handshake; inputs are scrambled while the event is in flight.
    task automatic send_event(input bit on, input logic [6:0] n, input logic [6:0] v);
        int lat;
        bit est, edr;
        lat = 0;
        @(negedge clk_in);
        chk("ready_before", note_ready_out, 1);
        note_valid_in = 1; note_on_in = on; note_in = n; velocity_in = v; all_off_in = 0;
        @(negedge clk_in);
        note_valid_in = 0;
        while (note_ready_out == 1'b0 && lat < 40) begin
            lat++;
            note_on_in = 1'($urandom); note_in = 7'($urandom);
            velocity_in = 7'($urandom); all_off_in = 1'($urandom);
            @(negedge clk_in);
        end
        all_off_in = 0;
        chk("latency", lat, 9);
        model_event(on, n, v, est, edr);
        chk("steal_pulse", steal_out, est);
        chk("drop_pulse", drop_out, edr);
        model_check("post");
        @(negedge clk_in);
        chk("steal_clear", steal_out, 0);
        chk("drop_clear", drop_out, 0);
    endtask

    task automatic panic_with_valid(input bit v);
        @(negedge clk_in);
        all_off_in = 1; note_valid_in = v; note_on_in = 1; note_in = 7'd5; velocity_in = 7'd9;
        chk("panic_ready", note_ready_out, 1);
        @(negedge clk_in);
        all_off_in = 0; note_valid_in = 0;
        for (int i = 0; i < NV; i++) begin m_gate[i] = 0; m_age[i] = 0; end
        chk("panic_not_accepted", note_ready_out, 1);
        model_check("panic");
        @(negedge clk_in);
        chk("panic_idle", note_ready_out, 1);
    endtask

    task automatic abort_test(input int k);
        send_event(1, 7'd33, 7'd44);
        @(negedge clk_in);
        note_valid_in = 1; note_on_in = 1; note_in = 7'd35; velocity_in = 7'd55;
        @(negedge clk_in);
        note_valid_in = 0;
        repeat (k - 1) @(negedge clk_in);
        #2 rst_n_in = 0;
        #1;
        chk("abort_gate", gate_out, 0);
        chk("abort_ready", note_ready_out, 1);
        @(negedge clk_in);
        rst_n_in = 1;
        model_clear();
        repeat (12) @(negedge clk_in);
        chk("abort_idle", note_ready_out, 1);
        chk("abort_pulse", {steal_out, drop_out}, 0);
        model_check("abort_after");
    endtask

    initial begin
        tbl[0] = '{1, 60, 100, 8'h01, 1, 0, 60, 100};
        tbl[1] = '{1, 62,  90, 8'h03, 2, 1, 62,  90};
        tbl[2] = '{1, 64,  80, 8'h07, 3, 2, 64,  80};
        tbl[3] = '{0, 62,  33, 8'h05, 2, 1, 62,  90};
        tbl[4] = '{1, 67,  70, 8'h07, 3, 1, 67,  70};
        tbl[5] = '{1, 60,  50, 8'h07, 3, 0, 60,  50};
        tbl[6] = '{0, 99,   5, 8'h07, 3, 2, 64,  80};
        tbl[7] = '{1, 72,   0, 8'h07, 3, 2, 64,  80};

        model_clear();
        do_reset();
        for (int r = 0; r < 8; r++) begin
            send_event(tbl[r].on, tbl[r].note, tbl[r].vel);
            chk($sformatf("tbl%0d_gate", r), gate_out, tbl[r].gate);
            chk($sformatf("tbl%0d_count", r), active_count_out, tbl[r].cnt);
            chk($sformatf("tbl%0d_note", r), voice_note_out[tbl[r].vi*7 +: 7], tbl[r].vnote);
            chk($sformatf("tbl%0d_vel", r), voice_vel_out[tbl[r].vi*7 +: 7], tbl[r].vvel);
        end

        // All voices busy, ninth note-on: steal voice 0 or drop.
        do_reset();
        for (int k = 0; k < 8; k++) send_event(1, 7'(60 + k), 7'd100);
        chk("full_gate", gate_out, 8'hFF);
        send_event(1, 7'd68, 7'd100);
        chk("ninth_gate", gate_out, 8'hFF);
`ifdef VOICE_ALLOC_STEAL_EN
        chk("ninth_v0_note", voice_note_out[6:0], 68);
`else
        chk("ninth_v0_note", voice_note_out[6:0], 60);
`endif
        send_event(1, 7'd69, 7'd90);

        // Zero-velocity note-off of voice 3, then panic with a colliding request.
        do_reset();
        send_event(1, 7'd10, 7'd1);
        send_event(1, 7'd11, 7'd2);
        send_event(1, 7'd12, 7'd3);
        send_event(1, 7'd72, 7'd90);
        send_event(1, 7'd72, 7'd0);
        chk("vel0_off_gate3", gate_out[3], 0);
        chk("vel0_off_gate", gate_out, 8'h07);
        for (int k = 0; k < 5; k++) send_event(1, 7'(20 + k), 7'd64);
        chk("refill_gate", gate_out, 8'hFF);
        panic_with_valid(1);
        chk("panic_gate", gate_out, 0);

        abort_test(1);
        abort_test(9);

        do_reset();
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 19) == 0)
                panic_with_valid(1'($urandom_range(0, 1)));
            else
                send_event($urandom_range(0, 9) < 7, 7'(40 + $urandom_range(0, 9)),
                           ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(1, 127)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
